// File: rtl/pwm_pio_pkg.sv
// Shared register map and channel mode encoding for the pwm_pio slave.
package pwm_pio_pkg;

  localparam logic [4:0] ADDR_DATA      = 5'h00;
  localparam logic [4:0] ADDR_MODE      = 5'h01;
  localparam logic [4:0] ADDR_PRESCALE  = 5'h02;
  localparam logic [4:0] ADDR_BLINK     = 5'h03;
  localparam logic [4:0] ADDR_SET       = 5'h04;
  localparam logic [4:0] ADDR_CLEAR     = 5'h05;
  localparam logic [4:0] ADDR_DUTY_BASE = 5'h10;

  typedef enum logic [1:0] {
    STATIC = 2'b00,
    BLINK  = 2'b01,
    PWM    = 2'b10,
    OFF    = 2'b11
  } mode_t;

endpackage

// File: rtl/pwm_pio_timebase.sv
// Shared timebase: prescaler tick, free-running PWM counter and blink phase.
module pwm_pio_timebase #(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic [15:0]              blink_half,
  input  logic                     resync,
  output logic                     tick,
  output logic [PWM_BITS-1:0]      pwm_cnt,
  output logic                     blink_phase
);

  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [15:0]              blink_cnt;

  assign tick = (pre_cnt == prescale);

  // Prescaler, PWM counter and blink half-period counter; resync beats a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (resync) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (blink_half == '0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == blink_half - 16'd1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
    end
  end

endmodule

// File: rtl/pwm_pio.sv
// Avalon-MM LED PIO with per-channel static, blink, PWM or off output modes.
module pwm_pio
  import pwm_pio_pkg::*;
#(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [4:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  output logic [WIDTH-1:0] pio_export
);

  logic [WIDTH-1:0]         data;
  logic [2*WIDTH-1:0]       mode;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [15:0]              blink_half;
  logic [PWM_BITS-1:0]      duty [WIDTH];

  logic                wr;
  logic                rd;
  logic                resync;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_phase;
  logic [31:0]         rd_mux;
  logic [WIDTH-1:0]    chan_next;
  logic                unused_bits;

  assign wr     = avs_chipselect & avs_write;
  assign rd     = avs_chipselect & avs_read;
  assign resync = wr & ((avs_address == ADDR_PRESCALE) | (avs_address == ADDR_BLINK));

  // Not every write-data bit is stored for every parameterisation; tick is internal to the timebase.
  assign unused_bits = ^{avs_writedata, tick};

  pwm_pio_timebase #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_timebase (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .prescale    (prescale),
    .blink_half  (blink_half),
    .resync      (resync),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  // Register file writes, including SET/CLEAR read-modify-write of DATA.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data       <= '0;
      mode       <= '0;
      prescale   <= '0;
      blink_half <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) duty[i] <= '0;
    end else if (wr) begin
      case (avs_address)
        ADDR_DATA:     data       <= avs_writedata[WIDTH-1:0];
        ADDR_MODE:     mode       <= avs_writedata[2*WIDTH-1:0];
        ADDR_PRESCALE: prescale   <= avs_writedata[PRESCALE_BITS-1:0];
        ADDR_BLINK:    blink_half <= avs_writedata[15:0];
        ADDR_SET:      data       <= data | avs_writedata[WIDTH-1:0];
        ADDR_CLEAR:    data       <= data & ~avs_writedata[WIDTH-1:0];
        default: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (avs_address == ADDR_DUTY_BASE + 5'(i)) duty[i] <= avs_writedata[PWM_BITS-1:0];
          end
        end
      endcase
    end
  end

  // Read mux: zero-extended register contents, 0 for write-only and unmapped words.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:     rd_mux[WIDTH-1:0]         = data;
      ADDR_MODE:     rd_mux[2*WIDTH-1:0]       = mode;
      ADDR_PRESCALE: rd_mux[PRESCALE_BITS-1:0] = prescale;
      ADDR_BLINK:    rd_mux[15:0]              = blink_half;
      default: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (avs_address == ADDR_DUTY_BASE + 5'(i)) rd_mux[PWM_BITS-1:0] = duty[i];
        end
      end
    endcase
  end

  // Read data is valid for exactly one cycle after the sampling edge, else 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (rd)        avs_readdata <= rd_mux;
    else                avs_readdata <= '0;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic ch_val;
    // Per-channel output select from its 2-bit mode field.
    always_comb begin
      ch_val = 1'b0;
      case (mode_t'(mode[2*gi +: 2]))
        STATIC:  ch_val = data[gi];
        BLINK:   ch_val = blink_phase & data[gi];
        PWM:     ch_val = (pwm_cnt < duty[gi]);
        default: ch_val = 1'b0;
      endcase
    end
    assign chan_next[gi] = ch_val;
  end

  // Registered pin outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) pio_export <= '0;
    else                pio_export <= chan_next;
  end

endmodule

// File: tb/tb_pwm_pio.sv
// Self-checking bench for pwm_pio: directed plan plus random bus traffic vs. a time-based model.
module tb_pwm_pio;
  import pwm_pio_pkg::*;

  localparam int unsigned WIDTH         = 10;
  localparam int unsigned PWM_BITS      = 8;
  localparam int unsigned PRESCALE_BITS = 16;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n;
  logic [4:0]       avs_address;
  logic             avs_chipselect;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic             avs_read;
  logic [31:0]      avs_readdata;
  logic [WIDTH-1:0] pio_export;

  always #5 clk_clk = ~clk_clk;

  pwm_pio #(
    .WIDTH         (WIDTH),
    .PWM_BITS      (PWM_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .pio_export     (pio_export)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus cycles elapsed since the last resync.
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_mode [WIDTH];
  int unsigned      m_duty [WIDTH];
  int unsigned      m_prescale;
  int unsigned      m_blink_half;
  longint unsigned  m_t;
  logic [WIDTH-1:0] m_exp_out;
  logic [31:0]      m_exp_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    for (int unsigned ch = 0; ch < WIDTH; ch++) begin
      m_mode[ch] = 2'b00;
      m_duty[ch] = 0;
    end
    m_prescale   = 0;
    m_blink_half = 0;
    m_t          = 0;
    m_exp_out    = '0;
    m_exp_rd     = '0;
  endtask

  // Output value implied by the registers and elapsed time.
  function automatic logic [WIDTH-1:0] model_out();
    longint unsigned  ticks = m_t / (longint'(m_prescale) + 1);
    longint unsigned  cnt   = ticks % (64'd1 << PWM_BITS);
    logic             ph;
    logic [WIDTH-1:0] o = '0;
    ph = (m_blink_half == 0) ? 1'b1 : (((ticks / m_blink_half) % 2) == 0);
    for (int unsigned ch = 0; ch < WIDTH; ch++) begin
      case (m_mode[ch])
        2'b00:   o[ch] = m_data[ch];
        2'b01:   o[ch] = m_data[ch] & ph;
        2'b10:   o[ch] = (cnt < m_duty[ch]);
        default: o[ch] = 1'b0;
      endcase
    end
    return o;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r = '0;
    case (a)
      5'h00: r[WIDTH-1:0] = m_data;
      5'h01: for (int unsigned ch = 0; ch < WIDTH; ch++) r[2*ch +: 2] = m_mode[ch];
      5'h02: r = m_prescale;
      5'h03: r = m_blink_half;
      default: if (a >= 5'h10 && (a - 5'h10) < WIDTH) r = m_duty[a - 5'h10];
    endcase
    return r;
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, output bit rs);
    rs = 1'b0;
    case (a)
      5'h00: m_data = d[WIDTH-1:0];
      5'h01: for (int unsigned ch = 0; ch < WIDTH; ch++) m_mode[ch] = d[2*ch +: 2];
      5'h02: begin m_prescale = d[15:0]; rs = 1'b1; end
      5'h03: begin m_blink_half = d[15:0]; rs = 1'b1; end
      5'h04: m_data = m_data | d[WIDTH-1:0];
      5'h05: m_data = m_data & ~d[WIDTH-1:0];
      default: if (a >= 5'h10 && (a - 5'h10) < WIDTH) m_duty[a - 5'h10] = d[PWM_BITS-1:0];
    endcase
  endtask

  // One clock: advance the model with the currently driven bus cycle, then compare.
  task automatic cycle();
    logic [WIDTH-1:0] out_next = model_out();
    logic [31:0]      rd_next  = (avs_chipselect && avs_read) ? model_read(avs_address) : 32'd0;
    bit               rs       = 1'b0;
    if (avs_chipselect && avs_write) model_write(avs_address, avs_writedata, rs);
    @(posedge clk_clk);
    #1;
    m_t       = rs ? 64'd0 : m_t + 1;
    m_exp_out = out_next;
    m_exp_rd  = rd_next;
    check("pio_export", 32'(pio_export), 32'(m_exp_out));
    check("readdata", avs_readdata, m_exp_rd);
  endtask

  task automatic bus_idle();
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    avs_read       = 1'b0;
    avs_address    = '0;
    avs_writedata  = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    cycle();
    bus_idle();
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] v);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = a;
    cycle();
    v = avs_readdata;
    bus_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [31:0]      rv;
    int               cnt;
    int unsigned      op;
    logic [4:0]       ra;
    logic [31:0]      rdat;

    reset_reset_n = 1'b0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk_clk);
    #1;
    check("reset_export", 32'(pio_export), 32'd0);
    check("reset_readdata", avs_readdata, 32'd0);
    reset_reset_n = 1'b1;

    // Every register reads 0 after reset, outputs stay low.
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), rv);
      check("reset_reg_read", rv, 32'd0);
    end
    for (int i = 0; i < 100; i++) begin
      cycle();
      check("idle_low", 32'(pio_export), 32'd0);
    end

    // Static mode with SET/CLEAR and OFF override.
    do_write(ADDR_DATA, 32'h2A5);
    check("data_lag", 32'(pio_export), 32'd0);
    cycle();
    check("static_data", 32'(pio_export), 32'h2A5);
    do_write(ADDR_SET, 32'h001);
    cycle();
    check("set_bit0", 32'(pio_export), 32'h2A5);
    do_write(ADDR_CLEAR, 32'h004);
    cycle();
    check("clear_bit2", 32'(pio_export), 32'h2A1);
    do_write(ADDR_MODE, 32'h000C0);
    cycle();
    check("mode_off", 32'(pio_export), 32'h2A1);
    do_write(ADDR_SET, 32'h008);
    cycle();
    check("off_forced", 32'(pio_export), 32'h2A1);

    // PWM on channel 0 with PRESCALE = 3.
    do_write(ADDR_MODE, 32'h2);
    do_write(ADDR_PRESCALE, 32'd3);
    do_write(ADDR_DUTY_BASE, 32'd64);
    cycle();
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin cycle(); cnt += int'(pio_export[0]); end
    check("pwm_duty64_high", 32'(cnt), 32'd256);
    do_write(ADDR_DUTY_BASE, 32'd0);
    cycle();
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin cycle(); cnt += int'(pio_export[0]); end
    check("pwm_duty0_high", 32'(cnt), 32'd0);
    do_write(ADDR_DUTY_BASE, 32'd255);
    cycle();
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin cycle(); cnt += int'(!pio_export[0]); end
    check("pwm_duty255_low", 32'(cnt), 32'd4);

    // Blink on channel 2, PRESCALE = 0, BLINK_HALF = 5.
    do_write(ADDR_MODE, 32'h10);
    do_write(ADDR_SET, 32'h004);
    do_write(ADDR_PRESCALE, 32'd0);
    do_write(ADDR_BLINK, 32'd5);
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("blink_pattern", 32'(pio_export[2]), ((k / 5) % 2 == 0) ? 32'd1 : 32'd0);
    end
    do_write(ADDR_CLEAR, 32'h004);
    cycle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin cycle(); cnt += int'(pio_export[2]); end
    check("blink_disabled", 32'(cnt), 32'd0);

    // Boundaries: DUTY beyond WIDTH, unmapped address, write-only registers.
    do_write(5'h1C, 32'hFF);
    do_read(5'h1C, rv);
    check("duty12_ignored", rv, 32'd0);
    do_read(5'h07, rv);
    check("unmapped_read", rv, 32'd0);
    do_read(ADDR_SET, rv);
    check("set_reads0", rv, 32'd0);
    do_read(ADDR_DUTY_BASE, rv);
    check("duty0_readback", rv, 32'd255);

    // PRESCALE rewrite mid-period restarts the PWM counter (DUTY = 1 marks count 0).
    do_write(ADDR_MODE, 32'h2);
    do_write(ADDR_DUTY_BASE, 32'd1);
    do_write(ADDR_PRESCALE, 32'd3);
    idle(37);
    check("pwm_mid_low", 32'(pio_export[0]), 32'd0);
    do_write(ADDR_PRESCALE, 32'd3);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("pwm_restart", 32'(pio_export[0]), (k < 4) ? 32'd1 : 32'd0);
    end

    // Random bus traffic against the model.
    for (int k = 0; k < 600; k++) begin
      op   = $urandom_range(0, 3);
      ra   = 5'($urandom_range(0, 31));
      rdat = $urandom();
      if (ra == ADDR_PRESCALE) rdat = $urandom_range(0, 3);
      if (ra == ADDR_BLINK)    rdat = $urandom_range(0, 6);
      if (op == 0)      do_write(ra, rdat);
      else if (op == 1) do_read(ra, rv);
      else              cycle();
    end

    // Reset asserted mid-PWM clears outputs before the next edge.
    do_write(ADDR_MODE, 32'h2);
    do_write(ADDR_DUTY_BASE, 32'd200);
    do_write(ADDR_PRESCALE, 32'd0);
    idle(5);
    check("pwm_high_before_reset", 32'(pio_export[0]), 32'd1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("async_reset_export", 32'(pio_export), 32'd0);
    check("async_reset_readdata", avs_readdata, 32'd0);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
    do_read(ADDR_DUTY_BASE, rv);
    check("duty0_after_reset", rv, 32'd0);
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
